odo_fuel_tracker: RTL

Vehicle-state accumulator that sits directly upstream of the dashboard LCD driver. It integrates vehicle speed into a wrapping odometer (km) and models fuel burn and refuelling as a 0–100 % level. It publishes `odometer`, `fuel` and status flags that the LCD stage renders as "ODO: nnnnn km" and "FUEL: nnn %". All arithmetic is evaluated on a slow sample tick derived from `clk`.

---
 rtl/odo_fuel_tracker.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/odo_fuel_tracker.sv
// Vehicle-state accumulator: odometer, fuel level, refuel FSM and optional trip meter.
// Define TRIP_METER_EN to build the 0.1 km trip counter; otherwise trip reads 0.
module odo_fuel_tracker #(
  parameter int TICK_DIV     = 5_000_000,
  parameter int DIST_UNIT    = 36000,
  parameter int BURN_UNIT    = 60000,
  parameter int IDLE_BURN    = 20,
  parameter int REFUEL_TICKS = 5,
  parameter int ODO_INIT     = 0,
  parameter int FUEL_INIT    = 100,
  parameter int LOW_FUEL     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        engine_on,
  input  logic [7:0]  speed,
  input  logic        refuel_req,
  input  logic        trip_clr,
  output logic [31:0] odometer,
  output logic [7:0]  fuel,
  output logic        fuel_low,
  output logic        fuel_empty,
  output logic        refuel_active,
  output logic [15:0] trip
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DIST_W = $clog2(DIST_UNIT + 256);
  localparam int BURN_W = $clog2(BURN_UNIT + IDLE_BURN + 256);
  localparam int RCNT_W = $clog2(REFUEL_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [DIST_W-1:0] DIST_U      = DIST_W'(DIST_UNIT);
  localparam logic [BURN_W-1:0] BURN_U      = BURN_W'(BURN_UNIT);
  localparam logic [BURN_W-1:0] BURN_IDLE   = BURN_W'(IDLE_BURN);
  localparam logic [RCNT_W-1:0] REFUEL_LAST = RCNT_W'(REFUEL_TICKS);
  localparam logic [31:0]       ODO_MAX     = 32'd99999;
  localparam logic [31:0]       ODO_RST     = 32'(ODO_INIT);
  localparam logic [7:0]        FUEL_FULL   = 8'd100;
  localparam logic [7:0]        FUEL_RST    = 8'(FUEL_INIT);
  localparam logic [7:0]        FUEL_LOW_TH = 8'(LOW_FUEL);
  localparam logic              LOW_RST     = (FUEL_INIT < LOW_FUEL);
  localparam logic              EMPTY_RST   = (FUEL_INIT == 0);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_REFUEL = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Sample-tick prescaler
  // ---------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Distance integration and odometer
  // ---------------------------------------------------------------------------
  logic [DIST_W-1:0] dist_acc, dist_sum, dist_next;
  logic [31:0]       odo_next;

  assign dist_sum = dist_acc + DIST_W'(speed);

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    dist_next = dist_acc;
    odo_next  = odometer;
    if (tick) begin
      if (dist_sum >= DIST_U) begin
        dist_next = dist_sum - DIST_U;
        odo_next  = (odometer == ODO_MAX) ? 32'd0 : odometer + 32'd1;
      end else begin
        dist_next = dist_sum;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fuel burn
  // ---------------------------------------------------------------------------
  logic [BURN_W-1:0] burn_acc, burn_sum, burn_next;
  logic              burn_dec;

  assign burn_sum = burn_acc + BURN_IDLE + BURN_W'(speed);

  always_comb begin
    burn_next = burn_acc;
    burn_dec  = 1'b0;
    if (fuel == 8'd0) begin
      burn_next = '0;
    end else if (tick && engine_on) begin
      if (burn_sum >= BURN_U) begin
        burn_next = burn_sum - BURN_U;
        burn_dec  = 1'b1;
      end else begin
        burn_next = burn_sum;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Refuel FSM
  // ---------------------------------------------------------------------------
  state_t            state, state_next;
  logic [RCNT_W-1:0] refuel_cnt, rcnt_next, rcnt_inc;
  logic              fuel_inc;
  logic              refuel_ok;

  assign rcnt_inc  = refuel_cnt + RCNT_W'(1);
  assign refuel_ok = refuel_req && !engine_on && (speed == 8'd0) && (fuel < FUEL_FULL);

  always_comb begin
    state_next = state;
    rcnt_next  = refuel_cnt;
    fuel_inc   = 1'b0;
    unique case (state)
      S_RUN: begin
        if (tick && refuel_ok) begin
          state_next = S_REFUEL;
          rcnt_next  = '0;
        end
      end
      S_REFUEL: begin
        // Abort is checked every clock and wins over a pending increment.
        if (!refuel_req || engine_on) begin
          state_next = S_RUN;
        end else if (tick) begin
          if (rcnt_inc == REFUEL_LAST) begin
            rcnt_next = '0;
            fuel_inc  = 1'b1;
            if (fuel == FUEL_FULL - 8'd1) begin
              state_next = S_HOLD;
            end
          end else begin
            rcnt_next = rcnt_inc;
          end
        end
      end
      S_HOLD: begin
        if (!refuel_req) begin
          state_next = S_RUN;
        end
      end
      default: state_next = S_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fuel level and flags (flags follow the next fuel value)
  // ---------------------------------------------------------------------------
  logic [7:0] fuel_next;

  always_comb begin
    fuel_next = fuel;
    if (fuel_inc) begin
      fuel_next = fuel + 8'd1;
    end else if (burn_dec) begin
      fuel_next = fuel - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_acc      <= '0;
      odometer      <= ODO_RST;
      burn_acc      <= '0;
      fuel          <= FUEL_RST;
      fuel_low      <= LOW_RST;
      fuel_empty    <= EMPTY_RST;
      state         <= S_RUN;
      refuel_cnt    <= '0;
      refuel_active <= 1'b0;
    end else begin
      dist_acc      <= dist_next;
      odometer      <= odo_next;
      burn_acc      <= burn_next;
      fuel          <= fuel_next;
      fuel_low      <= (fuel_next < FUEL_LOW_TH);
      fuel_empty    <= (fuel_next == 8'd0);
      state         <= state_next;
      refuel_cnt    <= rcnt_next;
      refuel_active <= (state_next == S_REFUEL);
    end
  end

  // ---------------------------------------------------------------------------
  // Trip meter (0.1 km resolution)
  // ---------------------------------------------------------------------------
`ifdef TRIP_METER_EN
  localparam int                TRIP_W  = $clog2(DIST_UNIT / 10 + 256);
  localparam logic [TRIP_W-1:0] TRIP_U  = TRIP_W'(DIST_UNIT / 10);
  localparam logic [15:0]       TRIP_MAX = 16'd9999;

  logic [TRIP_W-1:0] trip_acc, trip_sum;

  assign trip_sum = trip_acc + TRIP_W'(speed);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trip_acc <= '0;
      trip     <= '0;
    end else if (trip_clr) begin
      trip_acc <= '0;
      trip     <= '0;
    end else if (tick) begin
      if (trip_sum >= TRIP_U) begin
        trip_acc <= trip_sum - TRIP_U;
        trip     <= (trip == TRIP_MAX) ? 16'd0 : trip + 16'd1;
      end else begin
        trip_acc <= trip_sum;
      end
    end
  end
`else
  logic unused_trip_clr;

  assign unused_trip_clr = trip_clr;
  assign trip            = '0;
`endif

endmodule
